// File: rtl/whack_pkg.sv
// Shared whack-a-mole definitions: scheduler state encoding, board size
// and the 16-bit LFSR feedback polynomial.
package whack_pkg;

    localparam int NUM_HOLES_DEF = 18;

    // x^16 + x^14 + x^13 + x^11 + 1 in left-shifting Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SPAWN     = 2'd1,
        ST_MOLE_UP   = 2'd2,
        ST_MOLE_DOWN = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_scheduler_lfsr16.sv
// Free-running 16-bit maximal-length LFSR; never reaches zero from a
// non-zero seed.
module lfsr16
    import whack_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= seed;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mole_scheduler.sv
// Round scheduler: picks 1..MAX_MOLES random holes, raises them for a
// shrinking duration, then pauses before the next round.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int          NUM_HOLES      = NUM_HOLES_DEF,
    parameter int          UP_CYCLES_INIT = 50_000_000,
    parameter int          UP_CYCLES_MIN  = 10_000_000,
    parameter int          UP_STEP        = 2_000_000,
    parameter int          DOWN_CYCLES    = 25_000_000,
    parameter int          MAX_MOLES      = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 game_over,
    input  logic                 full_clear_hit,
    output logic [NUM_HOLES-1:0] mole_positions,
    output logic                 game_in_progress,
    output logic [7:0]           round_count
);

    localparam int          MAX_DUR   = (UP_CYCLES_INIT > DOWN_CYCLES) ? UP_CYCLES_INIT : DOWN_CYCLES;
    localparam int          CW        = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int          UW        = $clog2(UP_CYCLES_INIT + 1);
    localparam logic [31:0] DOWN_LAST = 32'(DOWN_CYCLES - 1);
    localparam logic [31:0] DEC_FLOOR = 32'(UP_CYCLES_MIN + UP_STEP);

    state_t               r_state, w_state_next;
    logic [15:0]          w_lfsr;
    logic [CW-1:0]        r_cnt;
    logic [UW-1:0]        r_up_len, w_up_len_dec;
    logic [4:0]           r_spawn_cnt;
    logic [2:0]           r_target, r_count, w_draw, w_target, w_count_next;
    logic [NUM_HOLES-1:0] r_pending, w_pending_next, w_sel, r_mole;
    logic [5:0]           w_idx;
    logic                 w_new, w_spawn_done, w_up_last, w_down_last;
    logic                 r_gip;
    logic [7:0]           r_round;
    logic                 w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:7];

    // Hole index folds 0..31 onto the board with a single subtraction.
    always_comb begin
        w_idx = {1'b0, w_lfsr[6:2]};
        if (w_idx >= 6'(NUM_HOLES)) begin
            w_idx = w_idx - 6'(NUM_HOLES);
        end
        for (int h = 0; h < NUM_HOLES; h++) begin
            w_sel[h] = (w_idx == 6'(h));
        end
    end

    assign w_new          = |(w_sel & ~r_pending);
    assign w_pending_next = r_pending | w_sel;
    assign w_count_next   = r_count + {2'b00, w_new};
    assign w_spawn_done   = (w_count_next == r_target) || (r_spawn_cnt == 5'd31);
    assign w_draw         = {1'b0, w_lfsr[1:0]} + 3'd1;
    assign w_target       = (w_draw > 3'(MAX_MOLES)) ? 3'(MAX_MOLES) : w_draw;
    assign w_up_last      = (32'(r_cnt) == 32'(r_up_len) - 32'd1);
    assign w_down_last    = (32'(r_cnt) == DOWN_LAST);
    assign w_up_len_dec   = (32'(r_up_len) >= DEC_FLOOR) ? UW'(32'(r_up_len) - 32'(UP_STEP))
                                                         : UW'(UP_CYCLES_MIN);

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (start && !game_over) w_state_next = ST_SPAWN;
            ST_SPAWN:     if (game_over) w_state_next = ST_IDLE;
                          else if (w_spawn_done) w_state_next = ST_MOLE_UP;
            ST_MOLE_UP:   if (game_over) w_state_next = ST_IDLE;
                          else if (full_clear_hit || w_up_last) w_state_next = ST_MOLE_DOWN;
            ST_MOLE_DOWN: if (game_over) w_state_next = ST_IDLE;
                          else if (w_down_last) w_state_next = ST_SPAWN;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_up_len    <= UW'(UP_CYCLES_INIT);
            r_spawn_cnt <= '0;
            r_target    <= '0;
            r_count     <= '0;
            r_pending   <= '0;
            r_mole      <= '0;
            r_gip       <= 1'b0;
            r_round     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_state_next == ST_SPAWN) begin
                        r_gip    <= 1'b1;
                        r_round  <= '0;
                        r_up_len <= UW'(UP_CYCLES_INIT);
                    end
                end
                ST_SPAWN: begin
                    r_pending   <= w_pending_next;
                    r_count     <= w_count_next;
                    r_spawn_cnt <= r_spawn_cnt + 5'd1;
                    if (w_state_next == ST_MOLE_UP) begin
                        r_mole <= w_pending_next;
                        r_cnt  <= '0;
                    end
                end
                ST_MOLE_UP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_state_next == ST_MOLE_DOWN) begin
                        r_mole   <= '0;
                        r_round  <= (r_round == 8'hFF) ? r_round : r_round + 8'd1;
                        r_up_len <= w_up_len_dec;
                        r_cnt    <= '0;
                    end
                end
                ST_MOLE_DOWN: r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
            // Later assignments win: spawn setup and the game-over clear override the above.
            if (w_state_next == ST_SPAWN && r_state != ST_SPAWN) begin
                r_target    <= w_target;
                r_pending   <= '0;
                r_count     <= '0;
                r_spawn_cnt <= '0;
            end
            if (w_state_next == ST_IDLE) begin
                r_mole <= '0;
                r_gip  <= 1'b0;
            end
        end
    end

    assign mole_positions   = r_mole;
    assign game_in_progress = r_gip;
    assign round_count      = r_round;

endmodule
